// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-stage constants, state encoding and alignment helper.
package rv_pkg;
  localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} fetch_state_t;
  function automatic logic isAligned(input logic [31:0] addr);
    return (addr & ~WORD_MASK) == '0;
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory bus, consumer handshake and redirect port of the fetch stage.
interface instr_fetch_unit_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic instr_ready;
  logic redirect;
  logic [31:0] redirect_pc;
  logic fetch_err;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    input imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} entries; flush overrides push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [63:0] pushData,
  output logic [$clog2(DEPTH):0] count,
  output logic [63:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  assign head = mem[rdPtr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(push);
      rdPtr <= rdPtr + AW'(pop);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk)
    if (push && !flush) mem[wrPtr] <= pushData;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues word fetches over req/ack, buffers them in a prefetch FIFO,
// and handles branch redirect with flush and squash of an in-flight request.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = DEFAULT_INITIAL_PC,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, nextState;
  logic [31:0] fetchPc, nextPc, reqAddr;
  logic fetchErr, nextErr, push, pop, flush, headValid, misalign;
  logic [CW-1:0] count;
  logic [63:0] head;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .pushData({fetchPc, bus.imem_rdata}), .count(count), .head(head)
  );

  // reqAddr is separate from fetchPc so a squashed request keeps its address while fetchPc moves on.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fetchPc <= INITIAL_PC;
      reqAddr <= INITIAL_PC;
      fetchErr <= 1'b0;
    end else begin
      state <= nextState;
      fetchPc <= nextPc;
      fetchErr <= nextErr;
      if (nextState == REQ) reqAddr <= nextPc;
    end

  always_comb begin
    headValid = count != '0;
    misalign = bus.redirect && !isAligned(bus.redirect_pc);
    pop = headValid && bus.instr_ready;
    flush = bus.redirect;
    push = state == REQ && bus.imem_ack && !bus.redirect;
    nextErr = fetchErr || misalign;
    nextPc = (bus.redirect && !misalign && state != HALT) ? bus.redirect_pc :
             push ? fetchPc + 32'd4 : fetchPc;
    nextState = state;
    // A misaligned redirect with a request still open waits in DROP for the ack, then halts.
    case (state)
      IDLE: nextState = misalign ? HALT :
                        (!bus.redirect && int'(count) < FIFO_DEPTH) ? REQ : IDLE;
      REQ:  nextState = bus.redirect ? (bus.imem_ack ? (misalign ? HALT : IDLE) : DROP) :
                        !bus.imem_ack ? REQ :
                        (int'(count) + 1 - int'(pop) < FIFO_DEPTH) ? REQ : IDLE;
      DROP: nextState = bus.imem_ack ? (nextErr ? HALT : IDLE) : DROP;
      default: nextState = HALT;
    endcase
  end

  always_comb begin
    bus.imem_req = state == REQ || state == DROP;
    bus.imem_addr = reqAddr;
    bus.instr_valid = headValid;
    bus.instr = headValid ? head[31:0] : '0;
    bus.instr_pc = headValid ? head[63:32] : '0;
    bus.fetch_err = fetchErr;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch sequencing, backpressure, redirect, error halt and async reset.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int nCmp = 0;
  int nErr = 0;

  instr_fetch_unit_if bus();
  instr_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  assign bus.imem_rdata = ~bus.imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 32'h0040_0000);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_err", 32'(bus.fetch_err), 0);

    // zero-wait streaming
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("s_req0", 32'(bus.imem_req), 1);
    chk("s_addr0", bus.imem_addr, 32'h0040_0000);
    chk("s_valid0", 32'(bus.instr_valid), 0);
    tick();
    chk("s_addr1", bus.imem_addr, 32'h0040_0004);
    chk("s_valid1", 32'(bus.instr_valid), 1);
    chk("s_pc1", bus.instr_pc, 32'h0040_0000);
    chk("s_instr1", bus.instr, 32'hFFBF_FFFF);
    tick();
    chk("s_addr2", bus.imem_addr, 32'h0040_0008);
    chk("s_pc2", bus.instr_pc, 32'h0040_0004);

    // backpressure fills the FIFO, then drains in order
    pulse_reset();
    bus.instr_ready = 1'b0;
    tick(3);
    chk("bp_req_full", 32'(bus.imem_req), 0);
    chk("bp_pc_head", bus.instr_pc, 32'h0040_0000);
    tick();
    chk("bp_req_hold", 32'(bus.imem_req), 0);
    bus.instr_ready = 1'b1;
    tick();
    chk("bp_pc_second", bus.instr_pc, 32'h0040_0004);
    chk("bp_req_wait", 32'(bus.imem_req), 0);
    tick();
    chk("bp_req_resume", 32'(bus.imem_req), 1);
    chk("bp_addr_resume", bus.imem_addr, 32'h0040_0008);
    chk("bp_valid_empty", 32'(bus.instr_valid), 0);

    // redirect while a request waits for a delayed ack
    pulse_reset();
    tick(2);
    chk("dr_addr_wait", bus.imem_addr, 32'h0040_0004);
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0040_0100;
    tick();
    bus.redirect = 1'b0;
    chk("dr_req_held", 32'(bus.imem_req), 1);
    chk("dr_addr_held", bus.imem_addr, 32'h0040_0004);
    chk("dr_valid_flush", 32'(bus.instr_valid), 0);
    tick();
    chk("dr_addr_held2", bus.imem_addr, 32'h0040_0004);
    bus.imem_ack = 1'b1;
    tick();
    chk("dr_req_idle", 32'(bus.imem_req), 0);
    chk("dr_valid_drop", 32'(bus.instr_valid), 0);
    tick();
    chk("dr_addr_new", bus.imem_addr, 32'h0040_0100);
    chk("dr_valid_gap", 32'(bus.instr_valid), 0);
    tick();
    chk("dr_pc_new", bus.instr_pc, 32'h0040_0100);
    chk("dr_instr_new", bus.instr, 32'hFFBF_FEFF);

    // redirect coinciding with an ack
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0040_0100;
    tick();
    bus.redirect = 1'b0;
    chk("ra_valid", 32'(bus.instr_valid), 0);
    chk("ra_req", 32'(bus.imem_req), 0);
    tick();
    chk("ra_req_new", 32'(bus.imem_req), 1);
    chk("ra_addr_new", bus.imem_addr, 32'h0040_0100);
    tick();
    chk("ra_pc", bus.instr_pc, 32'h0040_0100);

    // misaligned redirect halts fetching
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0040_0102;
    tick();
    bus.redirect = 1'b0;
    chk("me_err", 32'(bus.fetch_err), 1);
    chk("me_valid", 32'(bus.instr_valid), 0);
    chk("me_req", 32'(bus.imem_req), 0);
    tick(3);
    chk("me_req_halt", 32'(bus.imem_req), 0);
    rst_n = 1'b0;
    #1;
    chk("me_err_rst", 32'(bus.fetch_err), 0);
    rst_n = 1'b1;
    tick();
    chk("me_req_resume", 32'(bus.imem_req), 1);
    chk("me_addr_resume", bus.imem_addr, 32'h0040_0000);

    // misaligned redirect with a request outstanding keeps it until ack
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0040_0102;
    tick();
    bus.redirect = 1'b0;
    chk("mo_req_held", 32'(bus.imem_req), 1);
    chk("mo_addr_held", bus.imem_addr, 32'h0040_0000);
    chk("mo_err", 32'(bus.fetch_err), 1);
    bus.imem_ack = 1'b1;
    tick();
    chk("mo_req_done", 32'(bus.imem_req), 0);
    chk("mo_valid", 32'(bus.instr_valid), 0);

    // async reset mid-request
    pulse_reset();
    bus.instr_ready = 1'b0;
    tick(2);
    chk("ar_req_pre", 32'(bus.imem_req), 1);
    chk("ar_valid_pre", 32'(bus.instr_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.imem_req), 0);
    chk("ar_valid", 32'(bus.instr_valid), 0);
    chk("ar_pc", bus.instr_pc, 0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage upstream of the multicycle control FSM and datapath. Issues word-aligned read requests to instruction memory over a req/ack handshake and buffers returned words with their PC in a 2-entry prefetch FIFO. Presents one instruction at a time to the control FSM via valid/ready. Supports branch redirect with flush and squash of an in-flight request.

## Interface
- INITIAL_PC, 32'h00400000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2

- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- imem_req  out  1  read request, registered
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  FIFO head valid
- instr  out  32  head instruction; 0 when instr_valid=0
- instr_pc  out  32  head PC; 0 when instr_valid=0
- instr_ready  in  1  consumer accepts head this cycle
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
- redirect_pc  in  32  new fetch address
- fetch_err  out  1  sticky misaligned-redirect flag

## Operation
- Registers: fetch_pc (reset INITIAL_PC), state, FIFO, fetch_err.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, data kept.
  - DROP: request outstanding, data discarded.
  - HALT: error stop.
- IDLE→REQ when FIFO count < FIFO_DEPTH and no redirect. Set imem_req=1, imem_addr=fetch_pc.
- REQ, imem_ack=1, no redirect:
  - Push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32).
  - If count after push and pop < FIFO_DEPTH: stay REQ with the new address (back-to-back). Else go IDLE with imem_req=0.
- Handshake rule: once imem_req=1, it and imem_addr stay unchanged until imem_ack. The request is never withdrawn.
- Redirect with redirect_pc[1:0]==0:
  - FIFO flushed that cycle. Any pop that cycle is discarded. instr_valid=0 next cycle.
  - fetch_pc <= redirect_pc.
  - From REQ without ack: go DROP. Old request held until ack; ack data discarded. Then IDLE, and the next request follows per the IDLE rule.
  - From REQ with ack the same cycle: data discarded; go IDLE.
  - From DROP: update fetch_pc only; stay DROP.
- Redirect with redirect_pc[1:0]!=0:
  - Set fetch_err=1, flush FIFO, go HALT.
  - If a request is outstanding, hold imem_req until ack, then drop it.
  - HALT issues no requests. Only rst exits HALT.
- Pop when instr_valid && instr_ready. Push and pop in the same cycle are allowed; count unchanged.
- Overflow is impossible: at most 1 outstanding request, issued only when count < FIFO_DEPTH.

## Timing
- Reset (async, immediate, no clock needed):
  - imem_req=0, imem_addr=INITIAL_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - fetch_err=0, state IDLE, FIFO empty.
- First rising edge after rst deasserts: imem_req=1, imem_addr=INITIAL_PC.
- Latency: ack at edge N → instr_valid=1 after edge N. Head appears one cycle after ack.
- Zero-wait memory with ack held 1: one request per cycle.
- instr and instr_pc are FIFO-registered outputs, with no combinational path from imem_rdata.
- Reset mid-request abandons the transaction. The memory must tolerate a dropped req.

## Structure
- Shared package rv_pkg:
  - default INITIAL_PC
  - fetch state encoding typedef
  - NOP constant 32'h00000013
  - word-alignment mask
- Sub-module fetch_fifo:
  - synchronous FIFO with a 64-bit entry {pc, instr}
  - ports: push, pop, flush, count, head
  - flush has priority over push and pop
- Top module holds the FSM and the PC register.

## Test plan
- Reset release, ack=1 always, instr_ready=1:
  - imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
  - First instr_valid one cycle after the first ack, with instr_pc=0x00400000.
- instr_ready=0 with zero-wait memory:
  - Two pushes, then imem_req=0 with count=2.
  - Raise instr_ready: the next request is 0x00400008 and the FIFO order is preserved.
- Ack delayed 3 cycles on 0x00400004; redirect to 0x00400100 in cycle 1 of the wait:
  - imem_addr stays 0x00400004 until ack; its data is never seen.
  - Next request is 0x00400100. instr_valid=0 in between.
- Redirect to 0x00400100 in the same cycle as an ack:
  - Acked word dropped. FIFO empty next cycle.
  - Request for 0x00400100 issued per the IDLE rule.
- Redirect to 0x00400102:
  - fetch_err=1, instr_valid=0, no further imem_req.
  - Assert rst: fetch_err=0 and fetching resumes at 0x00400000.
- rst asserted between clock edges while imem_req=1:
  - imem_req=0 and instr_valid=0 immediately, without a clock edge.
